dmem_net_interface: RTL and testbench

- Sits directly downstream of the single-cycle datapath's data-memory port (address_rw, data_in, data_out).
- Serves local-node addresses from an internal RAM with zero-cycle reads.
- Forwards remote-node addresses as request packets over the photonic interconnect's valid/ready channel, and stalls the core until the response returns.

---
 rtl/dmem_net_pkg.sv | 12 +
 rtl/dmem_local_ram.sv | 15 +
 rtl/dmem_net_interface.sv | 107 ++++++++++
 tb/tb_dmem_net_interface.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_net_pkg.sv
// dmem_net_pkg: shared types and constants for the data-memory network interface
package dmem_net_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;
  localparam int DEST_W = 2;
  typedef struct packed {
    logic              write;
    logic [DEST_W-1:0] dest;
    logic [15:0]       addr;
    logic [15:0]       data;
  } req_t;
endpackage

// File: rtl/dmem_local_ram.sv
// dmem_local_ram: local word RAM with combinational read and clocked write
module dmem_local_ram #(
  parameter int LOCAL_AW = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LOCAL_AW-1:0] addr,
  input  logic [15:0]         wdata,
  output logic [15:0]         rdata
);
  logic [15:0] mem_q [2**LOCAL_AW];
  // commit stores on the edge; contents are deliberately left unreset
  always_ff @(posedge clk) if (we) mem_q[addr] <= wdata;
  assign rdata = mem_q[addr];
endmodule

// File: rtl/dmem_net_interface.sv
// dmem_net_interface: serves local addresses from RAM, forwards remote ones over the network
module dmem_net_interface
  import dmem_net_pkg::*;
#(
  parameter int NODE_W   = DEST_W,
  parameter int NODE_ID  = 0,
  parameter int LOCAL_AW = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       address_rw,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              stall,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_write,
  output logic [NODE_W-1:0] req_dest,
  output logic [15:0]       req_addr,
  output logic [15:0]       req_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [15:0]       rsp_data,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e         state_q, state_d;
  req_t           req_q, req_d, live, fields;
  logic [15:0]    rsp_q, rsp_d, ram_rdata;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           access, is_local, idle, remote, ram_we;
  assign access   = mem_read | mem_write;
  assign is_local = address_rw[15:16-NODE_W] == NODE_W'(NODE_ID);
  assign idle     = state_q == IDLE;
  assign remote   = rst & idle & access & !is_local;
  assign ram_we   = rst & idle & mem_write & is_local;
  assign live     = '{write: mem_write, dest: DEST_W'(address_rw[15:16-NODE_W]), addr: address_rw, data: data_in};
  assign fields   = idle ? live : req_q;

  dmem_local_ram #(.LOCAL_AW(LOCAL_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (address_rw[LOCAL_AW-1:0]),
    .wdata (data_in),
    .rdata (ram_rdata)
  );

  // next-state: issue, wait for handshake, wait for response or timeout, then complete
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (remote) begin
        req_d   = live;
        state_d = req_ready ? WAIT : REQ;
      end
      REQ:  if (req_ready) state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (rsp_valid) begin
          rsp_d   = req_q.write ? '0 : rsp_data;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_d   = ERR_DATA;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  // state and transaction registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_valid = remote | (rst & state_q == REQ);
  assign stall     = remote | (rst & (state_q == REQ | state_q == WAIT));
  assign rsp_ready = state_q != REQ;
  assign req_write = fields.write;
  assign req_dest  = NODE_W'(fields.dest);
  assign req_addr  = fields.addr;
  assign req_data  = fields.data;
  assign err       = err_q;
  assign data_out  = state_q == DONE ? rsp_q
                   : (idle & mem_read & !mem_write & is_local) ? ram_rdata : '0;
endmodule

// File: tb/tb_dmem_net_interface.sv
// tb_dmem_net_interface: vector table, hand sequences and randomized checks against a cycle-count model
module tb_dmem_net_interface;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0] address_rw = '0, data_in = '0;
  logic [15:0] data_out;
  logic        stall, req_valid, req_write, rsp_ready, err;
  logic        req_ready = 1'b0, rsp_valid = 1'b0;
  logic [1:0]  req_dest;
  logic [15:0] req_addr, req_data;
  logic [15:0] rsp_data = '0;
  int total = 0, bad = 0;
  logic        exp_err = 1'b0;
  logic [15:0] mdl [256];
  bit          vld [256];

  always #5 clk = ~clk;

  dmem_net_interface #(.NODE_W(2), .NODE_ID(0), .LOCAL_AW(8), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address_rw(address_rw), .data_in(data_in), .data_out(data_out), .stall(stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_dest(req_dest),
    .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .err(err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b0; mem_write = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  // one remote access; rdly = cycles with req_ready low, wdly = WAIT cycle of the response (0 = none)
  task automatic remote_op(input logic wr, input logic [15:0] a, input logic [15:0] dat,
                           input int rdly, input int wdly, input logic [15:0] rdata);
    int st = 0;
    int exp_len = (wdly == 0) ? rdly + 9 : rdly + wdly + 1;
    logic [15:0] exp_out = (wdly == 0) ? 16'hFFFF : (wr ? 16'h0000 : rdata);
    for (int k = 0; k < 60; k++) begin
      mem_read   = !wr;
      mem_write  = wr;
      address_rw = (k > 0 && k <= rdly) ? 16'($urandom) : a;
      data_in    = (k > 0 && k <= rdly) ? 16'($urandom) : dat;
      req_ready  = k >= rdly;
      rsp_valid  = wdly > 0 && k == rdly + wdly;
      rsp_data   = rsp_valid ? rdata : 16'($urandom);
      #2;
      if (!stall) break;
      st++;
      if (k <= rdly) begin
        check("req_valid", req_valid, 1);
        check("req_addr", req_addr, a);
        check("req_write", req_write, wr);
        check("req_dest", req_dest, a[15:14]);
        if (wr) check("req_data", req_data, dat);
        if (k > 0) check("rsp_ready_req", rsp_ready, 0);
      end else begin
        check("req_valid_wait", req_valid, 0);
        check("rsp_ready_wait", rsp_ready, 1);
      end
      cyc();
    end
    if (wdly == 0) exp_err = 1'b1;
    check("stall_len", st, exp_len);
    check("done_data", data_out, exp_out);
    check("err", err, exp_err);
    cyc();
    idle_inputs();
    #2;
    check("post_stall", stall, 0);
    check("post_data", data_out, 0);
    cyc();
  endtask

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h0005, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h0005, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 16'h00FF, 16'h1111, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 16'h2222, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h1111};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h2222};
    tbl[6] = '{1'b1, 1'b1, 16'h0010, 16'h3333, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h3333};
    tbl[8] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 1'b1, 16'h3F05, 16'h0000, 16'hBEEF};
    cyc();
    cyc();
    check("rst_stall", stall, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_err", err, 0);
    check("rst_data", data_out, 0);
    check("rst_rsp_ready", rsp_ready, 1);
    rst = 1'b1;
    cyc();
    foreach (tbl[i]) begin
      mem_write = tbl[i].wr; mem_read = tbl[i].rd; address_rw = tbl[i].a; data_in = tbl[i].d;
      #2;
      check("local_data", data_out, tbl[i].e);
      check("local_stall", stall, 0);
      check("local_req_valid", req_valid, 0);
      cyc();
    end
    idle_inputs();
    cyc();
    remote_op(1'b0, 16'h4010, 16'h0000, 0, 4, 16'h1234);
    remote_op(1'b0, 16'h8123, 16'h5A5A, 3, 2, 16'h0F0F);
    remote_op(1'b1, 16'hC002, 16'h00AA, 0, 3, 16'h7777);
    remote_op(1'b0, 16'h4444, 16'h0000, 1, 0, 16'h9999);
    rsp_valid = 1'b1; rsp_data = 16'hDEAD;
    #2;
    check("stray_ready", rsp_ready, 1);
    check("stray_stall", stall, 0);
    check("stray_data", data_out, 0);
    cyc();
    rsp_valid = 1'b0;
    #2;
    check("stray_after_stall", stall, 0);
    check("stray_after_valid", req_valid, 0);
    check("stray_after_data", data_out, 0);
    check("stray_err", err, 1);
    cyc();
    mem_read = 1'b1; address_rw = 16'h4000; req_ready = 1'b1;
    #2;
    check("wr_stall_idle", stall, 1);
    cyc();
    #2;
    check("wr_stall_wait", stall, 1);
    rst = 1'b0;
    #1;
    check("arst_stall", stall, 0);
    check("arst_req_valid", req_valid, 0);
    check("arst_err", err, 0);
    check("arst_data", data_out, 0);
    check("arst_rsp_ready", rsp_ready, 1);
    cyc();
    rst = 1'b1; req_ready = 1'b0; address_rw = 16'h0005;
    #2;
    check("after_rst_data", data_out, 16'hBEEF);
    check("after_rst_stall", stall, 0);
    check("after_rst_err", err, 0);
    exp_err = 1'b0;
    cyc();
    idle_inputs();
    cyc();
    for (int n = 0; n < 180; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [15:0] a = {2'($urandom_range(1, 3)), 14'($urandom)};
        remote_op(1'($urandom), a, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 8), 16'($urandom));
      end else begin
        int op = $urandom_range(0, 2);
        logic [7:0]  idx = 8'($urandom_range(32, 39));
        logic [15:0] d = 16'($urandom);
        mem_write = op == 0; mem_read = op == 1;
        address_rw = {2'b00, 6'($urandom), idx}; data_in = d;
        #2;
        check("rnd_stall", stall, 0);
        if (op == 1 && vld[idx]) check("rnd_read", data_out, mdl[idx]);
        if (op != 1) check("rnd_noload", data_out, 0);
        if (op == 0) begin
          mdl[idx] = d;
          vld[idx] = 1'b1;
        end
        cyc();
      end
    end
    idle_inputs();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
